// File: rtl/wb_cmd_mast.sv
// Command-driven Wishbone master: writes operands A/B/op to a register block,
// polls a status register, reads the result back and returns it as a response.
// Optional poll timeout is built when WB_CMD_MAST_TIMEOUT_EN is defined.
module wb_cmd_mast #(
  parameter logic [31:0] BASE_ADR = 32'h0000_0000,
  parameter int unsigned POLL_MAX = 1024
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [31:0] cmd_a_i,
  input  logic [31:0] cmd_b_i,
  input  logic [31:0] cmd_op_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_data_o,
  output logic        rsp_err_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_A, S_WR_B, S_WR_OP, S_POLL, S_RD_RES, S_RSP
  } state_e;

  localparam logic [31:0] OFS_A    = 32'h00;
  localparam logic [31:0] OFS_B    = 32'h04;
  localparam logic [31:0] OFS_OP   = 32'h08;
  localparam logic [31:0] OFS_RES  = 32'h0C;
  localparam logic [31:0] OFS_STAT = 32'h10;

  state_e      state_q, state_d;
  // Each bus state spends its strobe phase, then one idle gap cycle.
  logic        gap_q, gap_d;
  logic [31:0] a_q, a_d, b_q, b_d, op_q, op_d;
  logic        stat_q, stat_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_err_q, rsp_err_d;

  logic bus_state;
  logic stb_w;
  logic accept;
  logic done_ok;
  logic poll_expired;

  assign bus_state = (state_q == S_WR_A) || (state_q == S_WR_B) || (state_q == S_WR_OP) ||
                     (state_q == S_POLL) || (state_q == S_RD_RES);
  assign stb_w     = bus_state && !gap_q;
  assign accept    = (state_q == S_IDLE) && cmd_valid_i;
  assign done_ok   = stb_w && wb_ack_i && !wb_err_i;

`ifdef WB_CMD_MAST_TIMEOUT_EN
  localparam int CNT_W = $clog2(POLL_MAX + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign poll_expired = (cnt_q == CNT_W'(POLL_MAX));

  always_comb begin
    cnt_d = cnt_q;
    if (accept)
      cnt_d = '0;
    else if (state_q == S_POLL && done_ok)
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) cnt_q <= '0;
    else           cnt_q <= cnt_d;
  end
`else
  logic unused_poll_max;
  assign unused_poll_max = |POLL_MAX;
  assign poll_expired    = 1'b0;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q <= S_IDLE;
      gap_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
    end
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          state_d = S_WR_A;
          gap_d   = 1'b0;
        end
      end
      S_WR_A, S_WR_B, S_WR_OP, S_POLL, S_RD_RES: begin
        if (!gap_q) begin
          if (wb_err_i) begin
            state_d = S_RSP;
          end else if (wb_ack_i) begin
            gap_d = 1'b1;
          end
        end else begin
          gap_d = 1'b0;
          unique case (state_q)
            S_WR_A:  state_d = S_WR_B;
            S_WR_B:  state_d = S_WR_OP;
            S_WR_OP: state_d = S_POLL;
            S_POLL: begin
              if (stat_q)            state_d = S_RD_RES;
              else if (poll_expired) state_d = S_RSP;
              else                   state_d = S_POLL;
            end
            default: state_d = S_RSP;
          endcase
        end
      end
      S_RSP: begin
        if (rsp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: captured operands, last status bit and the response.
  always_comb begin
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    stat_d     = stat_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    if (accept) begin
      a_d  = cmd_a_i;
      b_d  = cmd_b_i;
      op_d = cmd_op_i;
    end
    if (state_q == S_POLL && done_ok) stat_d = wb_dat_i[0];
    if (stb_w && wb_err_i) begin
      rsp_data_d = 32'h0;
      rsp_err_d  = 1'b1;
    end else if (state_q == S_RD_RES && done_ok) begin
      rsp_data_d = wb_dat_i;
      rsp_err_d  = 1'b0;
    end else if (state_q == S_POLL && gap_q && !stat_q && poll_expired) begin
      rsp_data_d = 32'h0;
      rsp_err_d  = 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      a_q        <= 32'h0;
      b_q        <= 32'h0;
      op_q       <= 32'h0;
      stat_q     <= 1'b0;
      rsp_data_q <= 32'h0;
      rsp_err_q  <= 1'b0;
    end else begin
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      stat_q     <= stat_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // Bus outputs decode from registered state, so reset drops cyc/stb at once.
  always_comb begin
    wb_cyc_o = 1'b0;
    wb_stb_o = 1'b0;
    wb_we_o  = 1'b0;
    wb_sel_o = 4'h0;
    wb_adr_o = 32'h0;
    wb_dat_o = 32'h0;
    if (stb_w) begin
      wb_cyc_o = 1'b1;
      wb_stb_o = 1'b1;
      wb_sel_o = 4'hF;
      unique case (state_q)
        S_WR_A: begin
          wb_we_o  = 1'b1;
          wb_adr_o = BASE_ADR + OFS_A;
          wb_dat_o = a_q;
        end
        S_WR_B: begin
          wb_we_o  = 1'b1;
          wb_adr_o = BASE_ADR + OFS_B;
          wb_dat_o = b_q;
        end
        S_WR_OP: begin
          wb_we_o  = 1'b1;
          wb_adr_o = BASE_ADR + OFS_OP;
          wb_dat_o = op_q;
        end
        S_POLL:   wb_adr_o = BASE_ADR + OFS_STAT;
        S_RD_RES: wb_adr_o = BASE_ADR + OFS_RES;
        default:  wb_adr_o = 32'h0;
      endcase
    end
  end

  assign cmd_ready_o = (state_q == S_IDLE) && wb_rst_i;
  assign rsp_valid_o = (state_q == S_RSP);
  assign rsp_data_o  = rsp_data_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_wb_cmd_mast.sv
// Randomized bench for wb_cmd_mast: a Wishbone slave with random wait states,
// status delay and error injection, checked against a transaction-list model.
module tb_wb_cmd_mast;

  localparam logic [31:0] BASE   = 32'h8000_0040;
  localparam int          PMAX   = 8;
  localparam int          BUDGET = 3000;

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_a = '0, cmd_b = '0, cmd_op = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        wb_cyc, wb_stb, wb_we;
  logic [31:0] wb_adr, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel;
  logic        slv_ack, slv_err;

  wb_cmd_mast #(.BASE_ADR(BASE), .POLL_MAX(PMAX)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_a_i(cmd_a), .cmd_b_i(cmd_b), .cmd_op_i(cmd_op),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_data_o(rsp_data), .rsp_err_o(rsp_err),
    .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_we_o(wb_we),
    .wb_adr_o(wb_adr), .wb_sel_o(wb_sel), .wb_dat_o(wb_dat_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(slv_ack), .wb_err_i(slv_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Slave configuration, set by the stimulus between commands
  int          k_cfg = 0;
  logic [31:0] res_cfg = '0;
  int          err_at = -1;
  bit          err_both = 1'b0;
  bit          zero_wait = 1'b0;

  int          txn_cnt = 0;
  int          txn_base = 0;
  int          poll_done = 0;
  int          cyc_n = 0;
  int          proto_bad = 0;
  logic [1:0]  ws_left = 2'd0;
  logic [31:0] junk = 32'h5a5a_a5a5;
  txn_t        obs[$];

  always_comb begin
    slv_err  = wb_stb && (ws_left == 2'd0) && ((txn_cnt - txn_base) == err_at);
    slv_ack  = wb_stb && (ws_left == 2'd0) && (!slv_err || err_both);
    wb_dat_i = junk;
    if (wb_adr == BASE + 32'h10)      wb_dat_i = {junk[31:1], (poll_done >= k_cfg)};
    else if (wb_adr == BASE + 32'h0C) wb_dat_i = res_cfg;
  end

  always @(posedge clk) cyc_n <= cyc_n + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ws_left   <= 2'd0;
      poll_done <= 0;
    end else begin
      junk <= $urandom;
      if (!wb_cyc)                        ws_left <= zero_wait ? 2'd0 : 2'($urandom_range(0, 2));
      else if (wb_stb && ws_left != 2'd0) ws_left <= ws_left - 2'd1;
      if (slv_ack && !slv_err) begin
        if (wb_adr == BASE + 32'h10)        poll_done <= poll_done + 1;
        else if (wb_adr == BASE && wb_we)   poll_done <= 0;
      end
      if (wb_stb && (slv_ack || slv_err)) begin
        obs.push_back('{we: wb_we, adr: wb_adr, dat: wb_dat_o});
        txn_cnt <= txn_cnt + 1;
      end
    end
  end

  // Bus protocol watcher: stable strobe phase, idle gap, zeroed idle outputs
  logic        prev_stb = 1'b0, prev_term = 1'b0;
  logic [68:0] prev_vals = '0;
  always @(posedge clk or negedge rst_n) begin
    bit bad;
    if (!rst_n) begin
      prev_stb  <= 1'b0;
      prev_term <= 1'b0;
    end else begin
      bad = 1'b0;
      if (wb_cyc != wb_stb) bad = 1'b1;
      if (prev_stb && !prev_term && (!wb_stb || {wb_we, wb_adr, wb_dat_o, wb_sel} != prev_vals)) bad = 1'b1;
      if (prev_term && wb_cyc) bad = 1'b1;
      if (!wb_cyc && (wb_adr != 0 || wb_dat_o != 0 || wb_we || wb_sel != 0)) bad = 1'b1;
      if (wb_stb && (wb_sel != 4'hF || (!wb_we && wb_dat_o != 0))) bad = 1'b1;
      if (bad) proto_bad <= proto_bad + 1;
      prev_vals <= {wb_we, wb_adr, wb_dat_o, wb_sel};
      prev_stb  <= wb_stb;
      prev_term <= wb_stb && (slv_ack || slv_err);
    end
  end

  // Reference model: the bus transactions and response a command should produce
  txn_t        exp_q[$];
  logic [31:0] exp_data;
  logic        exp_err;
  int          t0;

  task automatic build_exp(input logic [31:0] a, b, op, res, input int k, input int ea);
    int  npoll;
    bit  tmo;
    exp_q.delete();
    exp_q.push_back('{we: 1'b1, adr: BASE + 32'h00, dat: a});
    exp_q.push_back('{we: 1'b1, adr: BASE + 32'h04, dat: b});
    exp_q.push_back('{we: 1'b1, adr: BASE + 32'h08, dat: op});
    npoll = k + 1;
    tmo   = 1'b0;
`ifdef WB_CMD_MAST_TIMEOUT_EN
    if (npoll > PMAX) begin
      npoll = PMAX;
      tmo   = 1'b1;
    end
`endif
    for (int i = 0; i < npoll; i++) exp_q.push_back('{we: 1'b0, adr: BASE + 32'h10, dat: 32'h0});
    if (!tmo) exp_q.push_back('{we: 1'b0, adr: BASE + 32'h0C, dat: 32'h0});
    exp_err  = tmo;
    exp_data = tmo ? 32'h0 : res;
    if (ea >= 0 && ea < exp_q.size()) begin
      while (exp_q.size() > ea + 1) void'(exp_q.pop_back());
      exp_err  = 1'b1;
      exp_data = 32'h0;
    end
  endtask

  task automatic start_cmd(input logic [31:0] a, b, op, res, input int k, input int ea,
                           input bit eb, input bit zw);
    int n;
    k_cfg     = k;
    res_cfg   = res;
    err_at    = ea;
    err_both  = eb;
    zero_wait = zw;
    txn_base  = txn_cnt;
    build_exp(a, b, op, res, k, ea);
    cmd_a     = a;
    cmd_b     = b;
    cmd_op    = op;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("accept_timeout", 96'd0, 96'd1);
    t0 = cyc_n + 1;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_a     = $urandom;
    cmd_b     = $urandom;
    cmd_op    = $urandom;
  endtask

  task automatic finish_cmd(input string name, input int hold, input bit chk_lat);
    int          n;
    int          hold_bad;
    int          nobs;
    logic [31:0] d0;
    n = 0;
    while (!rsp_valid && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    if (n >= BUDGET) begin
      check({name, "_rsp_timeout"}, 96'd0, 96'd1);
      return;
    end
    if (chk_lat) check({name, "_latency"}, 96'(cyc_n - t0), 96'd10);
    d0 = rsp_data;
    hold_bad = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!rsp_valid || rsp_data != d0 || cmd_ready || wb_cyc) hold_bad++;
    end
    if (hold > 0) check({name, "_hold"}, 96'(hold_bad), 96'd0);
    check({name, "_data"}, 96'(rsp_data), 96'(exp_data));
    check({name, "_err"}, 96'(rsp_err), 96'(exp_err));
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({name, "_ready_after"}, 96'({cmd_ready, rsp_valid}), 96'b10);
    nobs = txn_cnt - txn_base;
    check({name, "_ntxn"}, 96'(nobs), 96'(exp_q.size()));
    for (int i = 0; i < nobs && i < exp_q.size(); i++)
      check($sformatf("%s_txn%0d", name, i), 96'(obs[txn_base + i]), 96'(exp_q[i]));
    check({name, "_proto"}, 96'(proto_bad), 96'd0);
  endtask

  initial begin
    int n;
    #12;
    check("rst_bus", 96'({wb_cyc, wb_stb, wb_we, wb_sel}), 96'd0);
    check("rst_adr_dat", 96'({wb_adr, wb_dat_o}), 96'd0);
    check("rst_rsp", 96'({rsp_valid, rsp_err, rsp_data}), 96'd0);
    check("rst_cmd_ready", 96'(cmd_ready), 96'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_release_ready", 96'(cmd_ready), 96'd1);
    check("rst_release_valid", 96'(rsp_valid), 96'd0);

    start_cmd(32'h1234, 32'h1235, 32'h0, 32'h2469, 3, -1, 1'b0, 1'b0);
    finish_cmd("basic", 0, 1'b0);

    start_cmd(32'h1234, 32'h1235, 32'h0, 32'h2469, 0, -1, 1'b0, 1'b1);
    finish_cmd("zero_wait", 0, 1'b1);

    start_cmd(32'hdead_beef, 32'hcafe_f00d, 32'h7, 32'h1111_2222, 2, 1, 1'b0, 1'b0);
    finish_cmd("err_wr_b", 0, 1'b0);

    start_cmd(32'h0a0a_0a0a, 32'h0b0b_0b0b, 32'h3, 32'h3333_4444, 2, 4, 1'b1, 1'b0);
    finish_cmd("err_ack_poll", 0, 1'b0);

    start_cmd(32'h1, 32'h2, 32'h3, 32'h4, 0, 4, 1'b0, 1'b1);
    finish_cmd("err_rd_res", 0, 1'b0);

    start_cmd(32'h5555_aaaa, 32'haaaa_5555, 32'h1, 32'h9876_5432, 1, -1, 1'b0, 1'b0);
    finish_cmd("rsp_stall", 20, 1'b0);

    // Reset pulse while a status read is on the bus
    start_cmd(32'h77, 32'h88, 32'h99, 32'h1, 1000, -1, 1'b0, 1'b0);
    n = 0;
    while (!(wb_stb && wb_adr == BASE + 32'h10) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("mid_reset_reached_poll", 96'(n < 200), 96'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_reset_bus", 96'({wb_cyc, wb_stb, wb_adr}), 96'd0);
    check("mid_reset_rsp", 96'({rsp_valid, cmd_ready}), 96'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_reset_ready", 96'(cmd_ready), 96'd1);
    start_cmd(32'h1357, 32'h2468, 32'h5, 32'h0bad_cafe, 2, -1, 1'b0, 1'b0);
    finish_cmd("after_reset", 0, 1'b0);

`ifdef WB_CMD_MAST_TIMEOUT_EN
    start_cmd(32'h10, 32'h20, 32'h30, 32'h40, 1000, -1, 1'b0, 1'b0);
    finish_cmd("timeout", 0, 1'b0);
`endif

    for (int i = 0; i < 24; i++) begin
      int ea;
      ea = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 12)) : -1;
      start_cmd($urandom, $urandom, $urandom, $urandom, int'($urandom_range(0, 9)), ea,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      finish_cmd($sformatf("rnd%0d", i), int'($urandom_range(0, 4)), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
